// File: rtl/fu_issue_arb_pkg.sv
// fu_arb_pkg: shared widths, counter width and issue packet for the FU issue arbiter
package fu_arb_pkg;
  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int PERF_CNT_W = 32;
  typedef struct packed {
    logic [INST_ID_BITS-1:0] inst_id;
    logic [31:0] inst;
    logic [MAX_OPERANDS-1:0][63:0] op;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
    logic [63:0] pc;
  } issue_pkt_t;
endpackage

// File: rtl/fu_issue_arb_if.sv
// fu_issue_arb_if: requester ports, FU control side and squash; perf ports with FU_ISSUE_ARB_PERF_EN
import fu_arb_pkg::*;
interface fu_issue_arb_if #(parameter int NUM_REQ = 4);
  localparam int IDX_W = $clog2(NUM_REQ);
  logic flush;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [INST_ID_BITS-1:0] req_inst_id [NUM_REQ];
  logic [31:0] req_inst [NUM_REQ];
  logic [63:0] req_op [NUM_REQ][MAX_OPERANDS];
  logic [PRN_BITS-1:0] req_out_prn [NUM_REQ][MAX_OPERANDS];
  logic [63:0] req_pc [NUM_REQ];
  logic [INST_ID_BITS-1:0] inst_id;
  logic [31:0] inst;
  logic [63:0] op [MAX_OPERANDS];
  logic [PRN_BITS-1:0] out_prn [MAX_OPERANDS];
  logic [63:0] pc;
  logic inst_valid;
  logic fu_ready;
  logic [IDX_W-1:0] grant_idx;
`ifdef FU_ISSUE_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] perf_grants [NUM_REQ];
  logic [PERF_CNT_W-1:0] perf_stall;
`endif
  modport master (
`ifdef FU_ISSUE_ARB_PERF_EN
    output perf_grants, perf_stall,
`endif
    output req_ready, inst_id, inst, op, out_prn, pc, inst_valid, grant_idx,
    input flush, req_valid, req_inst_id, req_inst, req_op, req_out_prn, req_pc, fu_ready
  );
  modport slave (
`ifdef FU_ISSUE_ARB_PERF_EN
    input perf_grants, perf_stall,
`endif
    input req_ready, inst_id, inst, op, out_prn, pc, inst_valid, grant_idx,
    output flush, req_valid, req_inst_id, req_inst, req_op, req_out_prn, req_pc, fu_ready
  );
endinterface

// File: rtl/fu_issue_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from rr_ptr modulo NUM_REQ
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);
  logic found;
  logic [IDX_W-1:0] j;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (en && !found && req[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/fu_issue_arb.sv
// fu_issue_arb: round-robin issue of NUM_REQ requesters into one FU issue register.
// Define FU_ISSUE_ARB_PERF_EN to add saturating per-requester grant and stall counters.
import fu_arb_pkg::*;
module fu_issue_arb #(parameter int NUM_REQ = 4) (
  input logic clk,
  input logic rst,
  fu_issue_arb_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  logic slot_valid;
  logic load_en;
  logic [IDX_W-1:0] rr_ptr, win, grant_q;
  logic [NUM_REQ-1:0] gnt;
  issue_pkt_t pkt_q, pkt_d;
  // Reset gates the grant so no requester sees a handshake while rst is high
  assign load_en = !rst && !bus.flush && (!slot_valid || bus.fu_ready);
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(bus.req_valid),
    .rr_ptr(rr_ptr),
    .en(load_en),
    .gnt(gnt),
    .gnt_idx(win)
  );
  assign bus.req_ready = gnt;
  always_comb begin
    pkt_d.inst_id = bus.req_inst_id[win];
    pkt_d.inst = bus.req_inst[win];
    pkt_d.pc = bus.req_pc[win];
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      pkt_d.op[k] = bus.req_op[win][k];
      pkt_d.out_prn[k] = bus.req_out_prn[win][k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= 1'b0;
      rr_ptr <= '0;
      grant_q <= '0;
      pkt_q <= '0;
    end else if (bus.flush) begin
      slot_valid <= 1'b0;
    end else if (|gnt) begin
      slot_valid <= 1'b1;
      pkt_q <= pkt_d;
      grant_q <= win;
      rr_ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (bus.fu_ready) begin
      slot_valid <= 1'b0;
    end
  end
  assign bus.inst_valid = slot_valid;
  assign bus.inst_id = pkt_q.inst_id;
  assign bus.inst = pkt_q.inst;
  assign bus.pc = pkt_q.pc;
  assign bus.grant_idx = grant_q;
  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      bus.op[k] = pkt_q.op[k];
      bus.out_prn[k] = pkt_q.out_prn[k];
    end
  end
`ifdef FU_ISSUE_ARB_PERF_EN
  // Counters survive flush; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) bus.perf_grants[i] <= '0;
      bus.perf_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && bus.perf_grants[i] != '1) bus.perf_grants[i] <= bus.perf_grants[i] + 1'b1;
      if (slot_valid && !bus.fu_ready && bus.perf_stall != '1) bus.perf_stall <= bus.perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: doc/fu_issue_arb.md
# fu_issue_arb

Round-robin issue arbiter that shares one arithmetic functional unit among `NUM_REQ` reservation-station issue ports. Each cycle it selects one ready requester, latches its instruction into a single-entry issue register, and drives the FU control-side inputs (`inst_id`, `inst`, `op`, `out_prn`, `pc`, `inst_valid`) while honouring `fu_ready` back-pressure. It sits between the reservation stations and the FU's `fu_if` in the execute stage, and supports a pipeline squash.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `INST_ID_BITS`, 6: instruction tag width.
- `PRN_BITS`, 6: physical register number width.
- `MAX_OPERANDS`, 3: operand/destination slots per instruction.
- `clk` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous to `clk`, active-high.
- `flush` in 1: squash; empties the issue register and blocks grants in the same cycle.
- `req_valid[NUM_REQ]` in 1: requester i presents an instruction.
- `req_ready[NUM_REQ]` out 1: requester i is granted this cycle; one-hot or zero.
- `req_inst_id[NUM_REQ]` in INST_ID_BITS: tag.
- `req_inst[NUM_REQ]` in 32: encoding.
- `req_op[NUM_REQ][MAX_OPERANDS]` in 64: operand values.
- `req_out_prn[NUM_REQ][MAX_OPERANDS]` in PRN_BITS: destination PRNs.
- `req_pc[NUM_REQ]` in 64: PC.
- `inst_id`, `inst`, `op[MAX_OPERANDS]`, `out_prn[MAX_OPERANDS]`, `pc` out (widths as above): issue register contents, driven to the FU.
- `inst_valid` out 1: issue register holds a live instruction.
- `fu_ready` in 1: FU accepts `inst_*` this cycle.
- `grant_idx` out $clog2(NUM_REQ): index of the requester whose instruction is in the issue register.

## Operation
- Transfer on a requester port: `req_valid[i] && req_ready[i]`. Transfer to the FU: `inst_valid && fu_ready`.
- Issue register is a single entry. Occupancy flag `slot_valid` drives `inst_valid` directly.
- Load enable: `load_en = !flush && (!slot_valid || fu_ready)`.
- Arbitration:
  - When `load_en` is high, the winner is the first i with `req_valid[i]` set, scanning from `rr_ptr` upward modulo `NUM_REQ`.
  - `req_ready` is asserted only for the winner; all others are 0.
  - If `load_en` is 0, all `req_ready` are 0.
  - `req_ready` may depend combinationally on `req_valid`. It never depends on requester data.
- On a grant:
  - Latch the winner's fields and set `grant_idx` to the winner.
  - Set `slot_valid` to 1.
  - Set `rr_ptr` to (winner+1) mod `NUM_REQ`.
- FU consumes with no grant in the same cycle: `slot_valid` goes to 0.
- FU consumes and a grant occurs in the same cycle: new contents load with no bubble.
- No requester valid: `rr_ptr` holds.
- `slot_valid && !fu_ready`: all contents hold stable. This is required by the FU.
- `flush`:
  - Takes priority over everything else.
  - Next cycle, `slot_valid` is 0 and `rr_ptr` is unchanged.
  - No grant is made in the flush cycle.
- `rst`, sampled at the edge:
  - `slot_valid`, `rr_ptr`, `grant_idx`, `inst_id`, `inst`, `op`, `out_prn` and `pc` all reset to 0.
  - `req_ready` is 0 while `rst` is high.
  - Reset mid-stall drops the held instruction.

## Timing
- Latency: a grant at the cycle-N edge gives `inst_valid` in cycle N+1.
- Throughput: 1 instruction/cycle while `fu_ready` stays high.
- Fairness: a continuously valid requester is granted within `NUM_REQ` grants.
- The only combinational paths are `req_valid`/`fu_ready`/`flush` → `req_ready`. Data outputs are registered.

## Configuration
- `FU_ISSUE_ARB_PERF_EN` defined:
  - Adds `perf_grants[NUM_REQ]` out 32: per-requester grant counters.
  - Adds `perf_stall` out 32: cycles with `inst_valid && !fu_ready`.
  - All counters are saturating, and reset to 0 on `rst`.
  - Counters are not cleared by `flush`.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- `fu_arb_pkg` holds:
  - a packed `issue_pkt_t` struct {inst_id, inst, op, out_prn, pc};
  - `PERF_CNT_W` = 32.
- Sub-module `rr_arbiter`:
  - Parameterised by `NUM_REQ`.
  - Inputs: `req` vector, `rr_ptr`, `en`.
  - Outputs: one-hot `gnt` and `gnt_idx`.
  - Purely combinational. `fu_issue_arb` owns the `rr_ptr` register.

## Test plan
- Reset then idle: after `rst`, `inst_valid`=0 and `req_ready`=0; `op`=0 and `grant_idx`=0.
- All 4 valid, `fu_ready`=1 for 8 cycles: grants go 0,1,2,3,0,1,2,3; `inst_valid` is continuous from cycle 2.
- Back-pressure: requester 2 granted with `inst_id`=0x15, then `fu_ready`=0 for 3 cycles.
  - `inst_id` holds at 0x15 and `req_ready` stays 0 during the stall.
  - `fu_ready`=1 consumes the instruction and grants the next requester in the same cycle.
- Sparse requests: only requesters 1 and 3 valid from `rr_ptr`=2: grant 3, then 1, then 3.
- Flush while `slot_valid` with requester 0 valid: next cycle `inst_valid`=0 with no grant; requester 0 is granted the cycle after.
- With `FU_ISSUE_ARB_PERF_EN`: 5 grants to requester 1 plus 3 stall cycles gives `perf_grants[1]`=5 and `perf_stall`=3; `rst` zeroes both.
